spi_fifo_tx: RTL and testbench

SPI_FIFO_TX -- requirements
Module: spi_fifo_tx

---
 rtl/spi_fifo_tx_pkg.sv | 31 +++
 rtl/spi_fifo_tx_clkgen.sv | 35 +++
 rtl/spi_fifo_tx.sv | 111 +++++++++++
 tb/tb_spi_fifo_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_fifo_tx_pkg.sv
// Shared constants for the FIFO-fed SPI transmitter: FIFO flag encoding,
// SPI mode-0 line levels, counter widths and the transmitter FSM states.
package spi_fifo_tx_pkg;

  // FIFO flags are active low: a flag reading 0 means the condition holds.
  localparam logic true  = 1'b0;
  localparam logic false = 1'b1;

  // SPI mode 0: SCLK idles low, data changes on the falling edge.
  localparam logic sclk_idle = 1'b0;
  localparam logic mosi_idle = 1'b0;
  localparam logic cs_idle   = 1'b1;
  localparam logic cs_active = 1'b0;

  localparam int unsigned cnt_w = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP_HI = 3'd1,
    POP_LO = 3'd2,
    WAIT   = 3'd3,
    SHIFT  = 3'd4,
    GAP    = 3'd5
  } state_t;

  // One extra bit so the count can reach w itself without wrapping.
  function automatic int unsigned bit_cnt_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/spi_fifo_tx_clkgen.sv
// Half-period counter: holds at div-1 while stopped and fires a tick every
// div clks while running; the tick is split into SCLK rise/fall enables.
module spi_fifo_tx_clkgen
  import spi_fifo_tx_pkg::*;
#(
  parameter int unsigned div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sclk,
  output logic tick_c,
  output logic rise_c,
  output logic fall_c
);

  localparam logic [cnt_w-1:0] reload = cnt_w'(div - 1);

  logic [cnt_w-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run || cnt == '0) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - cnt_w'(1);
    end
  end

  assign tick_c = run && (cnt == '0);
  assign rise_c = tick_c && (sclk == sclk_idle);
  assign fall_c = tick_c && (sclk != sclk_idle);

endmodule

// File: rtl/spi_fifo_tx.sv
// Drains an active-low-flagged FIFO one word at a time and sends each word
// as an SPI mode-0 frame, MSB first, with a chip-select gap between frames.
module spi_fifo_tx
  import spi_fifo_tx_pkg::*;
#(
  parameter int unsigned dw  = 8,
  parameter int unsigned div = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [dw-1:0] fifo_odat,
  output logic          fifo_oen,
  output logic          sclk,
  output logic          mosi,
  output logic          cs_n,
  output logic          busy
);

  localparam int unsigned bw = bit_cnt_w(dw);

  state_t          state, state_next;
  logic [dw-1:0]   shreg, shreg_next;
  logic [bw-1:0]   bit_cnt, bit_cnt_next;
  logic            sclk_next;
  logic            fifo_oen_next, mosi_next, cs_n_next, busy_next;
  logic            fifo_avail_c;
  logic            run_c, tick_c, rise_c, fall_c;

  assign fifo_avail_c = en && (fifo_empty == false);
  assign run_c        = (state == SHIFT) || (state == GAP);

  spi_fifo_tx_clkgen #(.div(div)) u_spi_clkgen (
    .clk    (clk),
    .rst    (rst),
    .run    (run_c),
    .sclk   (sclk),
    .tick_c (tick_c),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      fifo_oen <= 1'b0;
      sclk     <= sclk_idle;
      mosi     <= mosi_idle;
      cs_n     <= cs_idle;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      fifo_oen <= fifo_oen_next;
      sclk     <= sclk_next;
      mosi     <= mosi_next;
      cs_n     <= cs_n_next;
      busy     <= busy_next;
    end
  end

  // Next state, datapath updates, and the registered-output values they imply.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    sclk_next    = sclk;

    case (state)
      IDLE: begin
        if (fifo_avail_c) state_next = POP_HI;
      end
      POP_HI: state_next = POP_LO;
      POP_LO: state_next = WAIT;
      WAIT: begin
        state_next   = SHIFT;
        shreg_next   = fifo_odat;
        bit_cnt_next = '0;
        sclk_next    = sclk_idle;
      end
      SHIFT: begin
        if (rise_c) begin
          sclk_next    = ~sclk_idle;
          bit_cnt_next = bit_cnt + bw'(1);
        end else if (fall_c) begin
          sclk_next = sclk_idle;
          // The last falling edge ends the frame; earlier ones expose the next bit.
          if (bit_cnt == bw'(dw)) begin
            state_next = GAP;
          end else begin
            shreg_next = shreg << 1;
          end
        end
      end
      GAP: begin
        if (tick_c) state_next = fifo_avail_c ? POP_HI : IDLE;
      end
      default: state_next = IDLE;
    endcase

    fifo_oen_next = (state_next == POP_HI);
    cs_n_next     = (state_next == SHIFT) ? cs_active : cs_idle;
    mosi_next     = (state_next == SHIFT) ? shreg_next[dw-1] : mosi_idle;
    busy_next     = (state_next != IDLE);
  end

endmodule

// File: tb/tb_spi_fifo_tx.sv
// Scoreboard bench for spi_fifo_tx: a queue-based FIFO model feeds the DUT and
// a negedge monitor rebuilds each SPI frame and checks it against the queue.
module tb_spi_fifo_tx;
  import spi_fifo_tx_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned DIV = 2;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          fifo_empty = true;
  logic [DW-1:0] fifo_odat  = '0;
  logic          fifo_oen, sclk, mosi, cs_n, busy;

  spi_fifo_tx #(.dw(DW), .div(DIV)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_odat  (fifo_odat),
    .fifo_oen   (fifo_oen),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: pops on the high-to-low edge of fifo_oen, registered read data.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          oen_d = 1'b0;

  always @(posedge clk) begin
    oen_d <= fifo_oen;
    if (oen_d && !fifo_oen && fifo_q.size() != 0) fifo_odat <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0) ? true : false;
  end

  // Monitor state
  int            cyc = 0, rd_idx = 0, nbits = 0;
  int            oen_rise_cyc = 0, cs_rise_cyc = 0, last_edge = 0;
  logic [DW-1:0] word = '0;
  logic          in_frame = 1'b0, pending = 1'b0, idle_watch = 1'b0;
  logic          oen_p = 1'b0, sclk_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0;
  logic          en_p = 1'b0, fifo_empty_p = true;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("rst_outputs", 32'({fifo_oen, sclk, mosi, cs_n, busy}), 32'(5'b00010));
      if (pending) rd_idx++;
      pending = 1'b0; in_frame = 1'b0; nbits = 0; word = '0;
      oen_p = 1'b0; sclk_p = 1'b0; cs_p = 1'b1; busy_p = 1'b0;
    end else begin
      if (idle_watch) chk("empty_quiet", 32'({fifo_oen, cs_n}), 32'(2'b01));
      if (fifo_oen && !oen_p) begin
        chk("pop_allowed", 32'({en_p, fifo_empty_p}), 32'({1'b1, false}));
        chk("one_pop_per_frame", 32'(pending), 0);
        chk("pop_source_nonempty", 32'(fifo_q.size() != 0), 1);
        if (busy_p) chk("gap_len", cyc - cs_rise_cyc, 32'(DIV));
        pending = 1'b1;
        oen_rise_cyc = cyc;
      end
      if (oen_p) chk("oen_width", 32'(fifo_oen), 0);
      if (!cs_n && cs_p) begin
        chk("pop_to_shift", cyc - oen_rise_cyc, 3);
        in_frame = 1'b1; nbits = 0; word = '0; last_edge = cyc;
      end
      if (in_frame && sclk != sclk_p) begin
        chk("half_period", cyc - last_edge, 32'(DIV));
        last_edge = cyc;
        if (sclk) begin
          word = (word << 1) | DW'(mosi);
          nbits++;
        end
      end
      if (cs_n && !cs_p) begin
        chk("frame_bits", nbits, 32'(DW));
        chk("sclk_end_low", 32'(sclk), 0);
        if (rd_idx < exp_q.size()) chk("frame_data", 32'(word), 32'(exp_q[rd_idx]));
        else chk("frame_extra", rd_idx, exp_q.size());
        rd_idx++;
        pending = 1'b0; in_frame = 1'b0; cs_rise_cyc = cyc;
      end
      if (!busy && busy_p) chk("idle_after_gap", cyc - cs_rise_cyc, 32'(DIV));
      oen_p = fifo_oen; sclk_p = sclk; cs_p = cs_n; busy_p = busy;
    end
    en_p = en;
    fifo_empty_p = fifo_empty;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic set_en(input logic v);
    step(1);
    en = v;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (!(rd_idx == exp_q.size() && busy == 1'b0 && fifo_q.size() == 0) && t < BUDGET) begin
      step(1);
      t++;
    end
    if (t >= BUDGET) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_bits(input string name, input int n);
    int t;
    t = 0;
    while (!(in_frame && nbits >= n) && t < BUDGET) begin
      step(1);
      t++;
    end
    if (t >= BUDGET) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int n;
    step(4);
    rst = 1'b1;

    // Enabled with nothing queued: no pop, chip select stays high.
    set_en(1'b1);
    idle_watch = 1'b1;
    step(100);
    idle_watch = 1'b0;

    // Single frame.
    push(8'hA5);
    wait_drain("single");
    chk("single_idle_busy", 32'(busy), 0);

    // Two frames queued before enabling.
    set_en(1'b0);
    push(8'h01);
    push(8'h80);
    set_en(1'b1);
    wait_drain("b2b");
    step(2);
    chk("b2b_fifo_empty", 32'(fifo_empty), 32'(true));

    // Dropping en mid-frame finishes the frame but blocks the next pop.
    set_en(1'b0);
    push(8'hFF);
    push(8'h3C);
    set_en(1'b1);
    wait_bits("en_drop_bits", 3);
    en = 1'b0;
    n = 0;
    while (busy && n < BUDGET) begin step(1); n++; end
    step(30);
    chk("en_drop_fifo_left", fifo_q.size(), 1);
    chk("en_drop_frames_left", exp_q.size() - rd_idx, 1);
    set_en(1'b1);
    wait_drain("en_drop");

    // Reset mid-frame discards the partial frame; IDLE acts on the next edge.
    set_en(1'b0);
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    set_en(1'b1);
    wait_bits("rst_bits", 4);
    rst = 1'b0;
    step(3);
    chk("rst_fifo_left", fifo_q.size(), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_pop_after_rst", 32'(fifo_oen), 1);
    wait_drain("rst");

    // Random bursts with random enable toggling.
    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) push(8'($urandom));
      en = ($urandom_range(0, 3) != 0);
      step(int'($urandom_range(5, 60)));
    end
    set_en(1'b1);
    wait_drain("random");

    chk("all_frames_seen", rd_idx, exp_q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
